fetch_unit: RTL and testbench

Instruction fetch stage feeding the decoder of the RV32 core. Generates sequential word-aligned PCs, issues pipelined requests to instruction memory over a req/gnt/rvalid handshake, and buffers up to DEPTH returned instructions with their PCs. Presents them downstream over valid/ready. A redirect (taken branch/jump) flushes the buffer, discards in-flight responses and restarts fetch at the new PC.

---
 rtl/core_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 81 ++++++++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RV32 core front end: data widths, the canonical
// NOP encoding and the {pc, inst} record carried by the fetch buffer.
package core_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, inst} entries. Head is read straight from the
// storage registers so downstream sees no combinational path from its inputs.
// Flush empties the buffer and wins over push/pop in the same cycle. A push
// while full is only accepted together with a pop, which frees the head slot
// that the write pointer is aliased to.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         head_valid,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] DEPTH_L = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok;
  logic          push_ok;

  assign pop_ok     = pop && (count_q != '0);
  assign push_ok    = push && ((count_q != DEPTH_L) || pop_ok);
  assign head       = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);
  assign count      = count_q;

  // Next pointers and occupancy; flush resets everything to empty.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage write: one slot per accepted push.
  always_comb begin
    mem_d = mem_q;
    if (push_ok && !flush) mem_d[wr_ptr_q] = push_data;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Issues sequential word-aligned requests under a
// credit limit (buffered + in-flight never exceeds DEPTH), tags each live
// response with the PC of the oldest live request, and buffers results for the
// decoder. A redirect flushes the buffer, marks every in-flight request as
// stale so its response is discarded, and restarts fetch at the new PC.
//
// Handshakes: imem request transfers when imem_req && imem_gnt; an issued
// request stays stable until granted unless a redirect or reset intervenes.
// Responses return in order, one per grant, flagged by imem_rvalid. The head
// instruction transfers to the consumer when inst_valid && inst_ready.
module fetch_unit
  import core_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   buf_count;
  logic [CW:0]     credit_used;
  logic [XLEN-1:0] redirect_aligned;
  logic            gnt_fire;
  logic            rsp_stale;
  logic            rsp_live;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;
  logic            unused_pc_bits;

  assign redirect_aligned = {redirect_pc[31:2], 2'b00};
  assign unused_pc_bits   = ^redirect_pc[1:0];

  // Credit: buffered plus in-flight must stay below DEPTH to issue another.
  assign credit_used = {1'b0, buf_count} + {1'b0, outstanding_q};
  assign imem_req    = !rst && (credit_used < DEPTH_L);
  assign imem_addr   = fetch_pc_q;
  assign gnt_fire    = imem_req && imem_gnt;

  // A response is stale if older stale requests remain or a redirect is
  // taking effect this cycle.
  assign rsp_stale = imem_rvalid && (drop_q != '0);
  assign rsp_live  = imem_rvalid && (drop_q == '0) && !redirect_valid;

  assign push_entry = '{pc: resp_pc_q, inst: imem_rdata};

  // In-flight and stale-response counters.
  always_comb begin
    outstanding_d = outstanding_q;
    if (gnt_fire && !imem_rvalid)      outstanding_d = outstanding_q + CW'(1);
    else if (!gnt_fire && imem_rvalid) outstanding_d = outstanding_q - CW'(1);

    drop_d = drop_q;
    if (redirect_valid)  drop_d = outstanding_d;
    else if (rsp_stale)  drop_d = drop_q - CW'(1);
  end

  // Request PC and the PC tag of the next live response.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_aligned;
      resp_pc_d  = redirect_aligned;
    end else begin
      if (gnt_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_live) resp_pc_d  = resp_pc_q + 32'd4;
    end
  end

  // Fetch state registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (rsp_live),
    .push_data  (push_entry),
    .pop        (inst_valid && inst_ready),
    .flush      (redirect_valid),
    .head       (head_entry),
    .head_valid (inst_valid),
    .count      (buf_count)
  );

  assign inst    = head_entry.inst;
  assign inst_pc = head_entry.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with random latency, random
// grant/ready, and a stream model (consumer must see consecutive PCs from the
// last start address, each carrying the memory word at that PC).
module tb_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] acc_q[$];
  logic [31:0] exp_q[$];

  int          n_cmp;
  int          n_bad;
  int          n_acc;
  int          n_grant;
  int          cyc;
  int          last_due;
  int          gnt_pct;
  int          rdy_pct;
  int          lat_min;
  int          lat_max;
  logic [31:0] exp_pc;
  logic        redir;
  logic [31:0] redir_pc;
  logic        hold;
  logic [31:0] hold_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    mq.delete();
    acc_q.delete();
    last_due = -1;
    hold     = 1'b0;
    exp_pc   = RESET_PC;
    cyc      = 0;
  endtask

  // One clock cycle; called at a falling edge, returns at the next one.
  task automatic tick();
    logic do_gnt;
    logic do_rv;
    logic do_rdy;
    int   d;
    #1;
    do_rv      = 1'b0;
    imem_rdata = 32'h0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      do_rv      = 1'b1;
      imem_rdata = mem_word(mq[0].addr);
    end
    do_gnt         = (int'($urandom_range(99)) < gnt_pct);
    do_rdy         = (int'($urandom_range(99)) < rdy_pct);
    imem_gnt       = do_gnt;
    imem_rvalid    = do_rv;
    inst_ready     = do_rdy;
    redirect_valid = redir;
    redirect_pc    = redir_pc;
    #1;
    if (!rst) begin
      if (hold) begin
        chk("req_hold", 32'(imem_req), 32'd1);
        chk("addr_hold", imem_addr, hold_addr);
      end
      if (imem_req) chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
    end
    if (inst_valid && do_rdy && !redir) begin
      chk("stream_pc", inst_pc, exp_pc);
      chk("stream_inst", inst, mem_word(exp_pc));
      acc_q.push_back(inst_pc);
      exp_pc = exp_pc + 32'd4;
      n_acc++;
    end
    if (do_rv) void'(mq.pop_front());
    if (imem_req && do_gnt) begin
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (d <= last_due) d = last_due + 1;
      mq.push_back('{addr: imem_addr, due: d});
      last_due = d;
      n_grant++;
      chk("credit", 32'(mq.size() <= DEPTH), 32'd1);
    end
    if (redir) exp_pc = {redir_pc[31:2], 2'b00};
    hold      = imem_req && !do_gnt && !redir && !rst;
    hold_addr = imem_addr;
    redir     = 1'b0;
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Run until one more instruction is accepted or the budget runs out.
  task automatic wait_accept(input string tag, input int budget, output logic [31:0] pc);
    int   a0;
    logic got;
    a0  = n_acc;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      got = (n_acc != a0);
    end
    chk({tag, "_timeout"}, 32'(got), 32'd1);
    pc = got ? acc_q[acc_q.size()-1] : 32'hDEAD_BEEF;
  endtask

  task automatic knobs(input int g, input int r, input int lmin, input int lmax);
    gnt_pct = g;
    rdy_pct = r;
    lat_min = lmin;
    lat_max = lmax;
  endtask

  initial begin
    int          first;
    logic        found;
    logic [31:0] pc;
    int          a0;
    int          g0;

    n_cmp = 0; n_bad = 0; n_acc = 0; n_grant = 0;
    rst = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
    redir = 1'b0; redir_pc = 32'h0;
    knobs(100, 100, 1, 1);
    reset_model();

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);

    // release: streaming with 1-cycle memory
    rst = 1'b0;
    reset_model();
    #1;
    chk("c0_req", 32'(imem_req), 32'd1);
    chk("c0_addr", imem_addr, RESET_PC);
    first = -1;
    a0    = n_acc;
    for (int i = 0; i < 24; i++) begin
      if (inst_valid && first < 0) first = cyc;
      tick();
    end
    chk("first_valid_cycle", 32'(first), 32'd2);
    chk("stream_progress", 32'(n_acc - a0 >= 10), 32'd1);

    // random grant/ready/latency with occasional redirects
    knobs(70, 70, 1, 4);
    a0 = n_acc;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 3) begin
        redir    = 1'b1;
        redir_pc = $urandom;
      end
      tick();
    end
    chk("random_progress", 32'(n_acc - a0 >= 40), 32'd1);

    // fixed 3-cycle latency, full throughput settings
    knobs(100, 100, 3, 3);
    a0 = n_acc;
    for (int i = 0; i < 40; i++) tick();
    chk("lat3_progress", 32'(n_acc - a0 >= 10), 32'd1);

    // redirect with two responses in flight
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (mq.size() == 2 && mq[0].due > cyc) found = 1'b1;
      else tick();
    end
    chk("e_setup", 32'(found), 32'd1);
    redir = 1'b1; redir_pc = 32'h0000_1002;
    tick();
    chk("e_valid_after", 32'(inst_valid), 32'd0);
    chk("e_addr_after", imem_addr, 32'h0000_1000);
    chk("e_req_after", 32'(imem_req), 32'(mq.size() < DEPTH));
    wait_accept("e_first", 60, pc);
    chk("e_first_pc", pc, 32'h0000_1000);

    // redirect in a cycle with both a grant and a live response
    knobs(100, 100, 1, 1);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (imem_req && mq.size() > 0 && mq[0].due <= cyc) found = 1'b1;
      else tick();
    end
    chk("f_setup", 32'(found), 32'd1);
    redir = 1'b1; redir_pc = 32'h0000_2000;
    g0 = n_grant;
    tick();
    chk("f_granted", 32'(n_grant - g0), 32'd1);
    chk("f_valid_after", 32'(inst_valid), 32'd0);
    chk("f_addr_after", imem_addr, 32'h0000_2000);
    wait_accept("f_first", 60, pc);
    chk("f_first_pc", pc, 32'h0000_2000);

    // redirect near the top of the address space: wrap to zero
    redir = 1'b1; redir_pc = 32'hFFFF_FFF8;
    tick();
    acc_q.delete();
    for (int i = 0; i < 60 && acc_q.size() < 3; i++) tick();
    exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    for (int i = 0; i < 3; i++)
      chk("wrap_pc", (i < acc_q.size()) ? acc_q[i] : 32'hDEAD_BEEF, exp_q[i]);

    // asynchronous reset mid-stream
    knobs(100, 0, 1, 1);
    for (int i = 0; i < 6; i++) tick();
    chk("h_pre_valid", 32'(inst_valid), 32'd1);
    #2;
    rst = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
    #1;
    chk("h_valid", 32'(inst_valid), 32'd0);
    chk("h_addr", imem_addr, RESET_PC);
    chk("h_req", 32'(imem_req), 32'd0);
    chk("h_inst_pc", inst_pc, 32'h0);
    reset_model();
    @(negedge clk);
    tick();
    tick();

    // back-pressure: exactly DEPTH grants, then requests stop
    rst = 1'b0;
    reset_model();
    g0 = n_grant;
    for (int i = 0; i < 10; i++) tick();
    chk("bp_grants", 32'(n_grant - g0), 32'(DEPTH));
    chk("bp_req", 32'(imem_req), 32'd0);
    chk("bp_valid", 32'(inst_valid), 32'd1);
    chk("bp_inst_pc", inst_pc, RESET_PC);
    knobs(100, 100, 1, 1);
    tick();
    chk("bp_resume_req", 32'(imem_req), 32'd1);

    // closing random run
    knobs(60, 60, 1, 3);
    a0 = n_acc;
    for (int i = 0; i < 100; i++) tick();
    chk("final_progress", 32'(n_acc - a0 >= 10), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
